multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Main control FSM of the multicycle RISC-V core.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback and drives datapath enables and mux selects.
- Sits directly upstream of the ALU decoder: its alu_op output feeds that decoder's ALUOp input, while op[5] and funct fields go to the decoder directly.
- Covers lw, sw, R-type, I-type ALU, jal and beq.

Parameters:
STATE_W, 4, width of state register and debug state port (minimum 4).

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  reset, synchronous, active-low
op  input  7  opcode from instruction register (instr[6:0])
zero  input  1  ALU zero flag
pc_write  output  1  PC enable = (branch & zero) | pc_update
branch  output  1  branch state indicator
pc_update  output  1  unconditional PC update
reg_write  output  1  register file write enable
mem_write  output  1  memory write enable
ir_write  output  1  instruction register enable
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 data
alu_src_b  output  2  00 rs2 data, 01 ImmExt, 10 constant 4
adr_src  output  1  0 PC, 1 Result
alu_op  output  2  00 add, 01 subtract (beq), 10 funct-decoded
illegal  output  1  unsupported opcode flag (see Optional Feature)
state  output  STATE_W  current state encoding, debug

Behaviour:
- Reset: when reset==0 at a rising clk, state <= FETCH (0), regardless of the current state, including mid-instruction. All outputs are Moore, so after reset they take the FETCH values.
- Outputs are pure combinational functions of state. No output depends on op. The only exception is pc_write, which also uses zero.
- Every output not listed for a state is 0. There are no X outputs.
- State encoding and asserted outputs:
  - FETCH=0: ir_write=1, pc_update=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - DECODE=1: alu_src_a=01, alu_src_b=01, alu_op=00.
  - MEMADR=2: alu_src_a=10, alu_src_b=01, alu_op=00.
  - MEMREAD=3: result_src=00, adr_src=1.
  - MEMWB=4: result_src=01, reg_write=1.
  - MEMWRITE=5: result_src=00, adr_src=1, mem_write=1.
  - EXECUTER=6: alu_src_a=10, alu_src_b=00, alu_op=10.
  - ALUWB=7: result_src=00, reg_write=1.
  - EXECUTEI=8: alu_src_a=10, alu_src_b=01, alu_op=10.
  - JAL=9: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
  - BEQ=10: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
  - ERROR=11: exists only with the Optional Feature.
- Transitions, one per rising clk:
  - FETCH -> DECODE.
  - DECODE on op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other opcode -> see Optional Feature
  - MEMADR: op==0000011 -> MEMREAD; otherwise -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER, EXECUTEI and JAL -> ALUWB.
  - ALUWB -> FETCH.
  - BEQ -> FETCH.
  - Unused encodings (12..15) -> FETCH on the next clk, outputs all 0.
- Cycle counts from entering FETCH to the next FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- op is sampled only in DECODE and MEMADR. It must be stable from the cycle after FETCH, when the IR is written.
- pc_write is combinational: asserted in FETCH and JAL, and in BEQ only when zero==1.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unsupported op in DECODE -> ERROR (11).
  - ERROR holds itself with illegal=1 and all other outputs 0.
  - Exit is only via reset==0.
- Not defined:
  - An unsupported op in DECODE -> FETCH (treated as a nop).
  - illegal is tied to 0 and the ERROR state is absent.

Test Plan:
1. Hold reset=0 for 2 clks with op=0110011, then release -> state=0, ir_write=1, pc_write=1, alu_src_b=10, result_src=10; next clk state=1.
2. lw (op=0000011) from FETCH -> state sequence 0,1,2,3,4,0; MEMREAD adr_src=1; MEMWB reg_write=1, result_src=01; mem_write never 1.
3. sw (op=0100011) -> sequence 0,1,2,5,0; MEMWRITE mem_write=1, adr_src=1; reg_write never 1.
4. R-type (0110011) -> 0,1,6,7,0 with alu_op=10 in state 6. I-type (0010011) -> 0,1,8,7,0 with alu_src_b=01.
5. beq (1100011) -> 0,1,10,0 with alu_op=01 and branch=1; in state 10, zero=1 gives pc_write=1 and zero=0 gives pc_write=0. jal (1101111) -> 0,1,9,7,0 with pc_write=1 in state 9.
6. op=1111111 in DECODE:
   - With ILLEGAL_OP_TRAP_EN: state=11, illegal=1, held for 5 clks; then reset=0 for one clk -> state=0, illegal=0.
   - Without: state returns to 0 after DECODE, illegal=0.
   - Either way, asserting reset=0 while in state 3 returns state to 0 on the next clk.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RISC-V core: Moore outputs from state, pc_write also uses zero; one state step per clk, no backpressure.
// ILLEGAL_OP_TRAP_EN: when defined, unsupported opcodes trap into a sticky ERROR state; otherwise they retire as nops.
module multicycle_main_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op,
   input  logic               zero,
   output logic               pc_write,
   output logic               branch,
   output logic               pc_update,
   output logic               reg_write,
   output logic               mem_write,
   output logic               ir_write,
   output logic [1:0]         result_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               adr_src,
   output logic [1:0]         alu_op,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
`ifdef ILLEGAL_OP_TRAP_EN
      ,S_ERROR   = 4'd11
`endif
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTER;
               OP_ITYPE:     state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
`ifdef ILLEGAL_OP_TRAP_EN
               default:      state_d = S_ERROR;
`else
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
         S_ERROR:    state_d = S_ERROR;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   // Encodings without a case arm (spares) fall through with every output at 0.
   always_comb begin
      branch     = 1'b0;
      pc_update  = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      adr_src    = 1'b0;
      alu_op     = 2'b00;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            pc_update  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_ALUWB: reg_write = 1'b1;
         S_EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
         end
`ifdef ILLEGAL_OP_TRAP_EN
         S_ERROR: illegal = 1'b1;
`endif
         default: ;
      endcase
   end

   assign pc_write = (branch & zero) | pc_update;
   assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: vector table plus hand-written reset/illegal-op sequences, checked through a scoreboard queue.
module tb_multicycle_main_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic       zero;
   logic       pc_write, branch, pc_update, reg_write, mem_write, ir_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic       adr_src, illegal;
   logic [3:0] state;

   always #5 clk = ~clk;

   multicycle_main_fsm #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero),
      .pc_write(pc_write), .branch(branch), .pc_update(pc_update),
      .reg_write(reg_write), .mem_write(mem_write), .ir_write(ir_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .adr_src(adr_src), .alu_op(alu_op), .illegal(illegal), .state(state)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       pc_write, branch, pc_update, reg_write, mem_write, ir_write;
      logic [1:0] result_src, alu_src_a, alu_src_b;
      logic       adr_src;
      logic [1:0] alu_op;
      logic       illegal;
   } out_t;

   typedef struct {
      logic       rst_n;
      logic [6:0] op;
      logic       zero;
      logic [3:0] st;
   } vec_t;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
   localparam logic [6:0] BAD = 7'b1111111;

   vec_t vecs[$];
   out_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Expected outputs for each state, written straight from the state table.
   function automatic out_t exp_outs(input logic [3:0] st, input logic z);
      out_t o = '0;
      o.st = st;
      case (st)
         4'd0:  begin o.ir_write = 1; o.pc_update = 1; o.pc_write = 1; o.alu_src_b = 2'b10; o.result_src = 2'b10; end
         4'd1:  begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
         4'd2:  begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
         4'd3:  o.adr_src = 1;
         4'd4:  begin o.result_src = 2'b01; o.reg_write = 1; end
         4'd5:  begin o.adr_src = 1; o.mem_write = 1; end
         4'd6:  begin o.alu_src_a = 2'b10; o.alu_op = 2'b10; end
         4'd7:  o.reg_write = 1;
         4'd8:  begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_op = 2'b10; end
         4'd9:  begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_update = 1; o.pc_write = 1; end
         4'd10: begin o.alu_src_a = 2'b10; o.alu_op = 2'b01; o.branch = 1; o.pc_write = z; end
         4'd11: o.illegal = 1;
         default: ;
      endcase
      return o;
   endfunction

   function automatic void add(input logic r, input logic [6:0] o, input logic z, input logic [3:0] s);
      vec_t v;
      v.rst_n = r; v.op = o; v.zero = z; v.st = s;
      vecs.push_back(v);
   endfunction

   task automatic check_out(input string name);
      out_t act, exp;
      act = '{state, pc_write, branch, pc_update, reg_write, mem_write, ir_write,
              result_src, alu_src_a, alu_src_b, adr_src, alu_op, illegal};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, actual=%h", name, act);
      end else begin
         exp = exp_q.pop_front();
         if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h (state %0d) required=%h (state %0d)",
                     name, act, act.st, exp, exp.st);
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      reset = v.rst_n;
      op    = v.op;
      zero  = v.zero;
      exp_q.push_back(exp_outs(v.st, v.zero));
      @(posedge clk);
      #1;
      check_out(name);
   endtask

   task automatic step(input logic r, input logic [6:0] o, input logic z, input logic [3:0] s, input string name);
      vec_t v;
      v.rst_n = r; v.op = o; v.zero = z; v.st = s;
      run_vec(v, name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; op = RT; zero = 1'b0;

      // reset held, then release into DECODE
      add(0, RT, 0, 0); add(0, RT, 0, 0);
      add(1, RT, 0, 1); add(1, RT, 0, 6); add(1, RT, 0, 7); add(1, RT, 0, 0);
      // lw
      add(1, LW, 0, 1); add(1, LW, 0, 2); add(1, LW, 0, 3); add(1, LW, 0, 4); add(1, LW, 0, 0);
      // sw
      add(1, SW, 0, 1); add(1, SW, 0, 2); add(1, SW, 0, 5); add(1, SW, 0, 0);
      // I-type
      add(1, IT, 0, 1); add(1, IT, 0, 8); add(1, IT, 0, 7); add(1, IT, 0, 0);
      // jal
      add(1, JL, 0, 1); add(1, JL, 0, 9); add(1, JL, 0, 7); add(1, JL, 0, 0);
      // beq taken, then not taken
      add(1, BQ, 1, 1); add(1, BQ, 1, 10); add(1, BQ, 1, 0);
      add(1, BQ, 0, 1); add(1, BQ, 0, 10); add(1, BQ, 0, 0);

      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // reset while in MEMREAD aborts the load
      step(1, LW, 0, 1, "mid_rst_dec");
      step(1, LW, 0, 2, "mid_rst_adr");
      step(1, LW, 0, 3, "mid_rst_rd");
      step(0, LW, 0, 0, "mid_rst_fetch");
      step(1, LW, 0, 1, "mid_rst_resume");
      step(1, LW, 0, 2, "mid_rst_adr2");
      step(1, LW, 0, 3, "mid_rst_rd2");
      step(1, LW, 0, 4, "mid_rst_wb2");
      step(1, LW, 0, 0, "mid_rst_fetch2");

      // unsupported opcode
      step(1, BAD, 0, 1, "bad_decode");
`ifdef ILLEGAL_OP_TRAP_EN
      step(1, BAD, 0, 11, "bad_trap");
      for (int i = 0; i < 5; i++)
         step(1, (i == 2) ? LW : BAD, i[0], 11, $sformatf("bad_hold%0d", i));
      step(0, BAD, 0, 0, "bad_reset");
      step(1, RT, 0, 1, "bad_after_rst");
`else
      step(1, BAD, 0, 0, "bad_nop");
      step(1, RT, 0, 1, "bad_after_nop");
`endif

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: actual=%0d left required=0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
